// File: rtl/bram_stream_pkg.sv
// Shared constants and helpers for the BRAM-backed stream FIFO.
package bram_stream_pkg;

  localparam int OBUF_DEPTH = 2;

  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
    return (ptr + 1 >= depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/bram_stream_obuf.sv
// Two-entry output buffer absorbing BRAM read responses; head word is registered.
// Push and pop may coincide at any fill level; a push into a full buffer without a pop is ignored.
module bram_stream_obuf
  import bram_stream_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       buf_count,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] slot0_q, slot0_d;
  logic [WIDTH-1:0] slot1_q, slot1_d;
  logic [1:0]       count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    pop_ok  = pop && (count_q != 2'd0);
    push_ok = push && ((count_q != 2'(OBUF_DEPTH)) || pop_ok);
    count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};

    // slot0 is always the head; a pop shifts slot1 forward.
    case (count_q)
      2'd0: begin
        if (push_ok) slot0_d = push_data;
      end
      2'd1: begin
        if (push_ok && pop_ok) slot0_d = push_data;
        else if (push_ok)      slot1_d = push_data;
      end
      2'd2: begin
        if (pop_ok) begin
          slot0_d = slot1_q;
          if (push_ok) slot1_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= '0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign buf_count  = count_q;
  assign head_valid = (count_q != 2'd0);
  assign head_data  = slot0_q;

endmodule

// File: rtl/bram_wrapper_verilog.sv
// Simple dual-port BRAM: synchronous write, read data and response valid one cycle after the request.
module bram_wrapper_verilog #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 10
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     w_valid,
  input  logic [$clog2(DEPTH)-1:0] w_address,
  input  logic [WIDTH-1:0]         w_data,
  input  logic                     ar_valid,
  input  logic [$clog2(DEPTH)-1:0] ar_address,
  output logic                     r_valid,
  output logic [WIDTH-1:0]         r_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] r_data_q;
  logic             r_valid_q, r_valid_d;

  always_comb r_valid_d = ar_valid;

  always_ff @(posedge clk) begin
    if (w_valid)  mem[w_address] <= w_data;
    if (ar_valid) r_data_q <= mem[ar_address];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_valid_q <= 1'b0;
    else          r_valid_q <= r_valid_d;
  end

  assign r_valid = r_valid_q;
  assign r_data  = r_data_q;

endmodule

// File: rtl/bram_stream_fifo.sv
// Stream FIFO using an external BRAM as storage with a 2-word prefetch buffer; 3-cycle first-word latency.
// i_ready depends only on BRAM occupancy; reads are throttled so buffered + in-flight never exceeds two.
module bram_stream_fifo
  import bram_stream_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 10
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_valid,
  output logic                       i_ready,
  input  logic [WIDTH-1:0]           i_data,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [WIDTH-1:0]           o_data,
  output logic                       w_valid,
  output logic [$clog2(DEPTH)-1:0]   w_address,
  output logic [WIDTH-1:0]           w_data,
  output logic                       ar_valid,
  output logic [$clog2(DEPTH)-1:0]   ar_address,
  input  logic                       r_valid,
  input  logic [WIDTH-1:0]           r_data,
  output logic [$clog2(DEPTH+3)-1:0] count,
  output logic                       err_unexpected
);

  localparam int AW = $clog2(DEPTH);
  localparam int MW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(DEPTH + 3);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [MW-1:0] mem_count_q, mem_count_d;
  logic          inflight_q, inflight_d;
  logic          err_q, err_d;
  logic          wr_en, rd_issue, push, pop;
  logic [1:0]    buf_count;

  always_comb begin
    i_ready  = reset_n && (mem_count_q < MW'(DEPTH));
    wr_en    = i_valid && i_ready;
    pop      = o_valid && o_ready;
    // Issue only if the response is guaranteed a slot, counting this cycle's pop.
    rd_issue = reset_n && (mem_count_q != '0) &&
               (({1'b0, buf_count} + {2'b00, inflight_q}) < (3'(OBUF_DEPTH) + {2'b00, pop}));
    push     = r_valid && inflight_q;

    w_valid    = wr_en;
    w_address  = wr_ptr_q;
    w_data     = i_data;
    ar_valid   = rd_issue;
    ar_address = rd_ptr_q;

    wr_ptr_d    = wr_en ? AW'(next_ptr(32'(wr_ptr_q), DEPTH)) : wr_ptr_q;
    rd_ptr_d    = rd_issue ? AW'(next_ptr(32'(rd_ptr_q), DEPTH)) : rd_ptr_q;
    mem_count_d = mem_count_q + MW'(wr_en) - MW'(rd_issue);
    inflight_d  = rd_issue;
    err_d       = err_q || (r_valid && !inflight_q);

    count          = CW'(mem_count_q) + CW'(inflight_q) + CW'(buf_count);
    err_unexpected = err_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
      inflight_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
      inflight_q  <= inflight_d;
      err_q       <= err_d;
    end
  end

  bram_stream_obuf #(.WIDTH(WIDTH)) u_obuf (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .push_data  (r_data),
    .pop        (pop),
    .buf_count  (buf_count),
    .head_valid (o_valid),
    .head_data  (o_data)
  );

endmodule
